capture_readout: RTL and testbench
==================================

// Module: capture_readout
//
// PURPOSE
// Parametrised successor to the capture-memory read path of the internal logic analyzer.
// Replays a burst of LENGTH samples from the synchronous capture RAM, starting at a
// caller-supplied address (normally the oldest sample, i.e. the write pointer after trigger).
// Addresses wrap modulo DEPTH. Output is a valid/ready stream with full backpressure, a
// last-word marker and an abort. Sits between the capture RAM and the host/UART readout.
//
// PARAMETERS
// DATA_WIDTH  8   sample width in bits
// ADDR_WIDTH  4   RAM address width; DEPTH = 2**ADDR_WIDTH
// CNT_WIDTH   ADDR_WIDTH+1  width of length/count fields (must hold DEPTH)
//
// PORTS
// clk        in   1            single clock
// reset      in   1            synchronous, active-high
// start      in   1            pulse: begin burst (accepted only when busy==0)
// start_addr in   ADDR_WIDTH   first RAM address to read
// length     in   CNT_WIDTH    words to read; 0 or >DEPTH means DEPTH
// abort      in   1            pulse: cancel burst, flush buffer
// rd_en      out  1            RAM read strobe
// rd_addr    out  ADDR_WIDTH   RAM read address
// rd_data    in   DATA_WIDTH   RAM data, valid the cycle after rd_en
// o_valid    out  1            stream valid
// o_ready    in   1            stream ready
// o_data     out  DATA_WIDTH   stream data
// o_last     out  1            high with the final word of the burst
// busy       out  1            burst in progress
// done       out  1            one-cycle pulse after final handshake
//
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, buffer empty, counters 0. Reset overrides every input.
// - FSM: IDLE -> (start) READ -> (all reads issued) DRAIN -> (last handshake) IDLE.
// - start sampled in IDLE at cycle N: latch start_addr/length, busy=1 from N+1;
//   first rd_en=1, rd_addr=start_addr at N+1; rd_data sampled at N+2; o_valid=1 from N+3.
// - start while busy: ignored. start and abort same cycle in IDLE: abort wins, no burst.
// - rd_addr increments by 1 per issued read; DEPTH-1 wraps to 0 (no carry).
// - Output buffer: 2-entry FIFO. A read issues only if (buffered + in-flight) < 2, so
//   no word is ever dropped under backpressure. Handshake = o_valid & o_ready.
// - With o_ready held high, sustained throughput is 1 word/clock after the first word.
// - o_data/o_valid/o_last stable while o_valid & !o_ready.
// - o_last=1 exactly on word number L (L = effective length), never otherwise.
// - done=1 for one cycle in the cycle after the last handshake; busy falls same cycle.
// - abort while busy: next cycle IDLE, busy=0, o_valid=0, buffer flushed, in-flight RAM
//   data discarded, done not asserted. abort in IDLE: no effect.
// - start may be accepted in the cycle done is high (busy already 0).
// - Reset mid-burst: same as abort plus all registers to reset values.
//
// TESTING
// 1 DEPTH=16, start_addr=3, length=4, o_ready=1 -> rd_addr 3,4,5,6; o_data=mem[3..6] on
//   consecutive cycles from N+3; o_last with mem[6]; done one cycle later.
// 2 start_addr=14, length=5 -> addresses 14,15,0,1,2 (wrap); o_last with mem[2].
// 3 length=0 -> 16 words from start_addr, o_last on 16th; length=17 -> also 16 words.
// 4 o_ready toggled 1,0,0,1,... random over length=8 -> all 8 words in order, none
//   dropped or duplicated; o_data held stable while stalled; rd_en never with buffer full.
// 5 abort after 2 handshakes of length=8 -> busy=0 next cycle, o_valid=0, no done;
//   new start then replays cleanly from its own start_addr.
// 6 start pulsed while busy, and start+abort together in IDLE -> both ignored; reset
//   asserted mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/capture_readout_if.sv
// rtl/capture_readout_if.sv - capture RAM read port and readout stream bundle
interface capture_readout_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  o_valid;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_last;

  modport master (
    output rd_en, rd_addr, o_valid, o_data, o_last,
    input  rd_data, o_ready
  );

  modport slave (
    input  rd_en, rd_addr, o_valid, o_data, o_last,
    output rd_data, o_ready
  );
endinterface

// File: rtl/capture_readout.sv
// rtl/capture_readout.sv - replays a wrapped burst from the capture RAM as a stream
module capture_readout #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [CNT_WIDTH-1:0]  length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  capture_readout_if.master     bus
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(2 ** ADDR_WIDTH);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  left_q;
  logic                  infl_q;
  logic                  infl_last_q;
  logic [1:0]            cnt_q;
  logic [DATA_WIDTH-1:0] d0_q, d1_q;
  logic                  l0_q, l1_q;
  logic                  done_q;

  logic [CNT_WIDTH-1:0]  eff_len;
  logic                  pop;
  logic [2:0]            occ;
  logic                  issue_ok;
  logic                  accept;
  logic                  flush;

  // A length of zero or beyond the RAM size replays the whole RAM once.
  assign eff_len = (length == '0 || length > DEPTH_C) ? DEPTH_C : length;

  assign accept = (state_q == IDLE) && start && !abort;
  assign flush  = (state_q != IDLE) && abort;

  assign bus.o_valid = (cnt_q != 2'd0);
  assign bus.o_data  = d0_q;
  assign bus.o_last  = bus.o_valid && l0_q;
  assign pop         = bus.o_valid && bus.o_ready;

  // Words held or on their way from the RAM once this cycle's pop is taken out.
  // Counting the pop keeps a full-rate stream at one word per clock.
  assign occ      = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
  assign issue_ok = (cnt_q != 2'd2) && (occ < 3'd2);

  assign bus.rd_en   = (state_q == READ) && issue_ok;
  assign bus.rd_addr = addr_q;

  assign busy = (state_q != IDLE);
  assign done = done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: abort beats everything, the last read moves to drain, last handshake ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = READ;
      READ: begin
        if (abort)                                      state_d = IDLE;
        else if (bus.rd_en && left_q == CNT_WIDTH'(1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort)                   state_d = IDLE;
        else if (pop && bus.o_last)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read address/count, in-flight tracking, the two-entry output buffer and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      left_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      d0_q        <= '0;
      d1_q        <= '0;
      l0_q        <= 1'b0;
      l1_q        <= 1'b0;
      done_q      <= 1'b0;
    end else if (flush) begin
      left_q      <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= 2'd0;
      done_q      <= 1'b0;
    end else begin
      done_q <= pop && bus.o_last;

      if (accept) begin
        addr_q <= start_addr;
        left_q <= eff_len;
      end else if (bus.rd_en) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        left_q <= left_q - CNT_WIDTH'(1);
      end

      infl_q      <= bus.rd_en;
      infl_last_q <= bus.rd_en && (left_q == CNT_WIDTH'(1));

      case ({infl_q, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            d0_q <= bus.rd_data;
            l0_q <= infl_last_q;
          end else begin
            d1_q <= bus.rd_data;
            l1_q <= infl_last_q;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          d0_q  <= d1_q;
          l0_q  <= l1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            d0_q <= bus.rd_data;
            l0_q <= infl_last_q;
          end else begin
            d0_q <= d1_q;
            l0_q <= l1_q;
            d1_q <= bus.rd_data;
            l1_q <= infl_last_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_readout.sv
// tb/tb_capture_readout.sv - directed bench for capture_readout
module tb_capture_readout;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] start_addr;
  logic [4:0] length;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] mem [16];
  int         checks = 0;
  int         errors = 0;

  capture_readout_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  capture_readout #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Synchronous capture RAM: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one burst from start_addr a, checking addresses, data order, o_last,
  // stall stability and buffer occupancy, then done/busy after the final word.
  task automatic run_burst(input logic [3:0] a, input logic [4:0] l, input int eff, input bit rnd);
    int         k;
    int         iss;
    int         cyc;
    bit         hs;
    bit         stalled;
    logic [7:0] pd;
    logic [3:0] ea;
    k = 0; iss = 0; cyc = 0; stalled = 0; pd = '0;
    start_addr = a; length = l; start = 1'b1;
    bus.o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk); #1; start = 1'b0;
    while (k < eff && cyc < 300) begin
      hs = bus.o_valid && bus.o_ready;
      if (stalled) begin
        chk("hold_valid", bus.o_valid, 1);
        chk("hold_data", bus.o_data, pd);
      end
      if (bus.rd_en) begin
        ea = a + iss[3:0];
        chk("rd_addr", bus.rd_addr, ea);
        chk("no_overflow", (iss - k - int'(hs)) < 2, 1);
        iss++;
      end
      if (bus.o_valid) chk("last", bus.o_last, k == eff - 1);
      if (hs) begin
        ea = a + k[3:0];
        chk("data", bus.o_data, mem[ea]);
        k++;
      end
      stalled = bus.o_valid && !bus.o_ready;
      pd = bus.o_data;
      @(negedge clk);
      if (rnd) bus.o_ready = 1'($urandom_range(0, 1));
      #1;
      cyc++;
    end
    chk("words", k, eff);
    chk("reads", iss, eff);
    chk("done_pulse", done, 1);
    chk("busy_fall", busy, 0);
    bus.o_ready = 1'b1;
    @(negedge clk); #1;
    chk("done_once", done, 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      logic [3:0] t;
      t = i[3:0];
      mem[i] = {t, ~t};
    end
    reset = 1'b1; start = 1'b1; abort = 1'b0; start_addr = 4'd5; length = 5'd3;
    bus.o_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_last", bus.o_last, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_addr", bus.rd_addr, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk); #1;

    // start_addr=3, length=4, cycle-exact pipeline timing.
    start_addr = 4'd3; length = 5'd4; start = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("t1_rd_en", bus.rd_en, c <= 4);
      if (c <= 4) chk("t1_rd_addr", bus.rd_addr, c + 2);
      chk("t1_valid", bus.o_valid, c >= 3 && c <= 6);
      if (c >= 3 && c <= 6) chk("t1_data", bus.o_data, mem[c]);
      chk("t1_last", bus.o_last, c == 6);
      chk("t1_busy", busy, c <= 6);
      chk("t1_done", done, c == 7);
      @(negedge clk); #1;
    end

    run_burst(4'd14, 5'd5, 5, 1'b0);
    run_burst(4'd7, 5'd0, 16, 1'b0);
    run_burst(4'd9, 5'd17, 16, 1'b0);
    run_burst(4'd5, 5'd8, 8, 1'b1);
    run_burst(4'd12, 5'd1, 1, 1'b1);

    // Abort after two handshakes.
    start_addr = 4'd2; length = 5'd8; start = 1'b1; bus.o_ready = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("t5_w0", bus.o_data, mem[2]);
    @(negedge clk); #1;
    chk("t5_w1", bus.o_data, mem[3]);
    @(negedge clk); abort = 1'b1; bus.o_ready = 1'b0; #1;
    chk("t5_busy_pre", busy, 1);
    @(negedge clk); abort = 1'b0; #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", bus.o_valid, 0);
    chk("t5_done", done, 0);
    chk("t5_rd_en", bus.rd_en, 0);
    @(negedge clk); #1;
    chk("t5_done_late", done, 0);
    chk("t5_valid_late", bus.o_valid, 0);
    run_burst(4'd10, 5'd3, 3, 1'b0);

    // start while busy is ignored.
    start_addr = 4'd0; length = 5'd4; start = 1'b1; bus.o_ready = 1'b1;
    @(negedge clk); #1; start = 1'b0;
    @(negedge clk); #1; start = 1'b1; start_addr = 4'd9; length = 5'd2;
    @(negedge clk); #1; start = 1'b0;
    for (int c = 3; c <= 9; c++) begin
      if (c <= 6) chk("t6_data", bus.o_data, mem[c - 3]);
      chk("t6_done", done, c == 7);
      if (c >= 7) begin
        chk("t6_idle", busy, 0);
        chk("t6_no_rd", bus.rd_en, 0);
      end
      @(negedge clk); #1;
    end

    // start together with abort in IDLE is ignored.
    start_addr = 4'd6; length = 5'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk); #1; start = 1'b0; abort = 1'b0;
    chk("t6_sa_busy", busy, 0);
    chk("t6_sa_rd", bus.rd_en, 0);
    @(negedge clk); #1;
    chk("t6_sa_valid", bus.o_valid, 0);

    // Reset mid-burst with the buffer full.
    start_addr = 4'd0; length = 5'd8; start = 1'b1; bus.o_ready = 1'b0;
    @(negedge clk); #1; start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t6_full", bus.o_valid, 1);
    reset = 1'b1;
    @(negedge clk); #1; reset = 1'b0;
    chk("t6_r_busy", busy, 0);
    chk("t6_r_done", done, 0);
    chk("t6_r_rd_en", bus.rd_en, 0);
    chk("t6_r_addr", bus.rd_addr, 0);
    chk("t6_r_valid", bus.o_valid, 0);
    chk("t6_r_data", bus.o_data, 0);
    chk("t6_r_last", bus.o_last, 0);
    run_burst(4'd1, 5'd2, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
